// File: rtl/shifter_pipe_param.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with opaque tag passthrough; optional carry_out under SHIFTER_CARRY_OUT_EN.
// Latency: STAGES cycles from accept to out_valid, 1 op/cycle sustained.
// Backpressure: whole pipe stalls (bubbles included) when out_valid & ~out_ready; in_ready = ~out_valid | out_ready.
module shifter_pipe_param #(
    parameter int WIDTH     = 32,
    parameter int SA_WIDTH  = 5,
    parameter int STAGES    = 2,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     opB,
    input  logic [SA_WIDTH-1:0]  sa,
    input  logic [2:0]           op,
    input  logic [TAG_WIDTH-1:0] tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic [TAG_WIDTH-1:0] tag_out
`ifdef SHIFTER_CARRY_OUT_EN
    ,
    output logic                 carry_out
`endif
);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;
    localparam logic [SA_WIDTH-1:0] SA_ONE = SA_WIDTH'(1);

    typedef struct packed {
        logic                 vld;
        logic [WIDTH-1:0]     dat;
        logic [SA_WIDTH-1:0]  sa;
        logic [2:0]           op;
        logic [TAG_WIDTH-1:0] tag;
        logic                 sign;
`ifdef SHIFTER_CARRY_OUT_EN
        logic                 carry;
`endif
    } stage_t;

    // Shift-amount bits owned by stage s; the high bits land in the early stages.
    function automatic logic [SA_WIDTH-1:0] stage_mask(input int s);
        logic [SA_WIDTH-1:0] m;
        m = '0;
        for (int j = 0; j < SA_WIDTH; j++)
            if (((SA_WIDTH - 1 - j) * STAGES) / SA_WIDTH == s)
                m[j] = 1'b1;
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] shift_dat(input logic [WIDTH-1:0] d,
                                                   input logic [SA_WIDTH-1:0] k,
                                                   input logic [2:0] o,
                                                   input logic sgn);
        logic [2*WIDTH-1:0] dd;
        logic [WIDTH-1:0]   r;
        dd = {d, d};
        r  = d;
        case (o)
            OP_SLL: r = d << k;
            OP_SRL: r = d >> k;
            OP_SRA: r = (d >> k) | (sgn ? ~({WIDTH{1'b1}} >> k) : '0);
            OP_ROL: begin
                dd = dd << k;
                r  = dd[2*WIDTH-1:WIDTH];
            end
            OP_ROR: begin
                dd = dd >> k;
                r  = dd[WIDTH-1:0];
            end
            default: r = d;
        endcase
        return r;
    endfunction

`ifdef SHIFTER_CARRY_OUT_EN
    // Outermost bit lost by this sub-shift; composes across stages because each
    // stage sees the partially shifted word.
    function automatic logic shift_carry(input logic [WIDTH-1:0] d,
                                         input logic [SA_WIDTH-1:0] k,
                                         input logic [2:0] o,
                                         input logic c);
        logic [WIDTH-1:0] t;
        logic             r;
        t = '0;
        r = c;
        if (k != '0) begin
            case (o)
                OP_SLL: begin
                    t = d << (k - SA_ONE);
                    r = t[WIDTH-1];
                end
                OP_SRL, OP_SRA: begin
                    t = d >> (k - SA_ONE);
                    r = t[0];
                end
                default: r = c;
            endcase
        end
        return r;
    endfunction
`endif

    logic                 adv;
    logic                 out_vld_q;
    logic [WIDTH-1:0]     result_q;
    logic [TAG_WIDTH-1:0] tag_q;
    stage_t               fresh;
    stage_t               pipe_in [STAGES];

    assign adv       = ~out_vld_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = out_vld_q;
    assign result    = result_q;
    assign tag_out   = tag_q;

    always_comb begin
        fresh      = '0;
        fresh.vld  = in_valid;
        fresh.dat  = opB;
        fresh.sa   = sa;
        fresh.op   = op;
        fresh.tag  = tag_in;
        fresh.sign = opB[WIDTH-1];
    end

    assign pipe_in[0] = fresh;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam logic [SA_WIDTH-1:0] MASK = stage_mask(s);
        logic [SA_WIDTH-1:0] k;
        logic [WIDTH-1:0]    dat_nxt;

        assign k       = pipe_in[s].sa & MASK;
        assign dat_nxt = shift_dat(pipe_in[s].dat, k, pipe_in[s].op, pipe_in[s].sign);
`ifdef SHIFTER_CARRY_OUT_EN
        logic carry_nxt;
        assign carry_nxt = shift_carry(pipe_in[s].dat, k, pipe_in[s].op, pipe_in[s].carry);
`endif

        if (s < STAGES - 1) begin : g_mid
            stage_t nxt;
            stage_t q;

            always_comb begin
                nxt     = pipe_in[s];
                nxt.dat = dat_nxt;
`ifdef SHIFTER_CARRY_OUT_EN
                nxt.carry = carry_nxt;
`endif
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn)
                    q <= '0;
                else if (adv)
                    q <= nxt;
            end

            assign pipe_in[s+1] = q;
        end else begin : g_last
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    out_vld_q <= 1'b0;
                    result_q  <= '0;
                    tag_q     <= '0;
                end else if (adv) begin
                    out_vld_q <= pipe_in[s].vld;
                    result_q  <= dat_nxt;
                    tag_q     <= pipe_in[s].tag;
                end
            end

`ifdef SHIFTER_CARRY_OUT_EN
            logic carry_q;
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn)
                    carry_q <= 1'b0;
                else if (adv)
                    carry_q <= carry_nxt;
            end
            assign carry_out = carry_q;
`endif
        end
    end

endmodule

// File: tb/tb_shifter_pipe_param.sv
// Directed-vector bench for shifter_pipe_param: latency, streaming order/tags, backpressure hold, reset.
module tb_shifter_pipe_param;

    localparam int WIDTH     = 32;
    localparam int SA_WIDTH  = 5;
    localparam int STAGES    = 2;
    localparam int TAG_WIDTH = 4;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    logic                 clk;
    logic                 resetn;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     opB;
    logic [SA_WIDTH-1:0]  sa;
    logic [2:0]           op;
    logic [TAG_WIDTH-1:0] tag_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     result;
    logic [TAG_WIDTH-1:0] tag_out;
`ifdef SHIFTER_CARRY_OUT_EN
    logic                 carry_out;
`endif

    shifter_pipe_param #(
        .WIDTH(WIDTH), .SA_WIDTH(SA_WIDTH), .STAGES(STAGES), .TAG_WIDTH(TAG_WIDTH)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .opB(opB),
        .sa(sa),
        .op(op),
        .tag_in(tag_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .tag_out(tag_out)
`ifdef SHIFTER_CARRY_OUT_EN
        ,
        .carry_out(carry_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  s;
        logic [2:0]  o;
        logic [3:0]  t;
        logic [31:0] e;
    } vec_t;

    vec_t        vecs [18];
    logic [35:0] exp_q [$];
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    task automatic drive(input logic [31:0] a, input logic [4:0] s, input logic [2:0] o,
                         input logic [3:0] t);
        in_valid = 1'b1;
        opB      = a;
        sa       = s;
        op       = o;
        tag_in   = t;
    endtask

    // One op into an idle pipe; checks exact latency and the trailing bubble.
    task automatic run_single(input logic [31:0] a, input logic [4:0] s, input logic [2:0] o,
                              input logic [3:0] t, input logic [31:0] e, input logic ec);
        @(negedge clk);
        out_ready = 1'b1;
        drive(a, s, o, t);
        for (int c = 1; c < STAGES; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk("lat_early_vld", out_valid, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_vld", out_valid, 1);
        chk("lat_res", result, e);
        chk("lat_tag", tag_out, t);
`ifdef SHIFTER_CARRY_OUT_EN
        chk("lat_carry", carry_out, ec);
`else
        if (ec === 1'bx) chk("lat_carry_x", out_valid, 1);
`endif
        @(negedge clk);
        chk("lat_bubble", out_valid, 0);
    endtask

    task automatic run_stream(input int lo, input int hi, input bit bp);
        int          idx;
        int          cyc;
        int          first_pop;
        int          last_pop;
        bit          held_vld;
        logic [31:0] held_res;
        logic [3:0]  held_tag;
        logic [35:0] e;
        idx       = lo;
        cyc       = 0;
        first_pop = -1;
        last_pop  = -1;
        held_vld  = 1'b0;
        held_res  = '0;
        held_tag  = '0;
        while ((idx <= hi || exp_q.size() > 0) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (held_vld) begin
                chk("hold_res", result, held_res);
                chk("hold_tag", tag_out, held_tag);
            end
            out_ready = bp ? !((cyc % 8) inside {4, 5, 6}) : 1'b1;
            if (idx <= hi)
                drive(vecs[idx].a, vecs[idx].s, vecs[idx].o, vecs[idx].t);
            else
                in_valid = 1'b0;
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_vld", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("str_res", result, e[31:0]);
                    chk("str_tag", tag_out, e[35:32]);
                    if (first_pop < 0) first_pop = cyc;
                    last_pop = cyc;
                end
            end
            held_vld = out_valid && !out_ready;
            held_res = result;
            held_tag = tag_out;
            if (held_vld)
                chk("bp_in_rdy", in_ready, 0);
            if (in_valid && in_ready) begin
                exp_q.push_back({vecs[idx].t, vecs[idx].e});
                idx++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("str_drain", exp_q.size(), 0);
        chk("str_all_sent", idx, hi + 1);
        if (!bp)
            chk("b2b_span", last_pop - first_pop, hi - lo);
    endtask

    initial begin
        vecs[0]  = '{32'h0000_0001, 5'd31, OP_SLL, 4'h1, 32'h8000_0000};
        vecs[1]  = '{32'h8000_0000, 5'd31, OP_SRL, 4'h2, 32'h0000_0001};
        vecs[2]  = '{32'h8000_0001, 5'd1,  OP_ROL, 4'h3, 32'h0000_0003};
        vecs[3]  = '{32'h8000_0001, 5'd1,  OP_ROR, 4'h4, 32'hC000_0000};
        vecs[4]  = '{32'hDEAD_BEEF, 5'd0,  OP_SLL, 4'h5, 32'hDEAD_BEEF};
        vecs[5]  = '{32'hDEAD_BEEF, 5'd0,  OP_SRL, 4'h6, 32'hDEAD_BEEF};
        vecs[6]  = '{32'hDEAD_BEEF, 5'd0,  OP_SRA, 4'h7, 32'hDEAD_BEEF};
        vecs[7]  = '{32'hDEAD_BEEF, 5'd0,  OP_ROL, 4'h8, 32'hDEAD_BEEF};
        vecs[8]  = '{32'hDEAD_BEEF, 5'd0,  OP_ROR, 4'h9, 32'hDEAD_BEEF};
        vecs[9]  = '{32'hDEAD_BEEF, 5'd0,  3'b111, 4'hA, 32'hDEAD_BEEF};
        vecs[10] = '{32'hDEAD_BEEF, 5'd7,  3'b010, 4'hB, 32'hDEAD_BEEF};
        vecs[11] = '{32'h7000_0000, 5'd3,  OP_SRA, 4'hC, 32'h0E00_0000};
        vecs[12] = '{32'h8000_0000, 5'd31, OP_SRA, 4'hD, 32'hFFFF_FFFF};
        vecs[13] = '{32'h1234_5678, 5'd8,  OP_ROL, 4'hE, 32'h3456_7812};
        vecs[14] = '{32'h1234_5678, 5'd4,  OP_ROR, 4'hF, 32'h8123_4567};
        vecs[15] = '{32'hF0F0_F0F0, 5'd5,  OP_SRL, 4'h0, 32'h0787_8787};
        vecs[16] = '{32'h0000_00FF, 5'd28, OP_SLL, 4'h1, 32'hF000_0000};
        vecs[17] = '{32'h1234_5678, 5'd3,  3'b110, 4'h2, 32'h1234_5678};

        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        opB       = '0;
        sa        = '0;
        op        = '0;
        tag_in    = '0;
        repeat (3) @(negedge clk);
        chk("rst_vld", out_valid, 0);
        chk("rst_res", result, 0);
        chk("rst_tag", tag_out, 0);
        chk("rst_in_rdy", in_ready, 1);
`ifdef SHIFTER_CARRY_OUT_EN
        chk("rst_carry", carry_out, 0);
`endif
        resetn = 1'b1;

        run_single(32'h8000_0001, 5'd4, OP_SRA, 4'h3, 32'hF800_0000, 1'b0);
        run_stream(0, 3, 1'b0);
        run_stream(4, 17, 1'b1);

        // Two ops in flight, then asynchronous reset between clock edges.
        @(negedge clk);
        drive(32'hFFFF_FFFF, 5'd1, OP_SLL, 4'h7);
        @(negedge clk);
        drive(32'h0000_0F00, 5'd4, OP_SRL, 4'h8);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_res", result, 0);
        chk("mid_rst_tag", tag_out, 0);
        in_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        run_single(32'h0000_00F0, 5'd8, OP_ROR, 4'h9, 32'hF000_0000, 1'b0);

`ifdef SHIFTER_CARRY_OUT_EN
        run_single(32'h4000_0000, 5'd2, OP_SLL, 4'h1, 32'h0000_0000, 1'b1);
        run_single(32'h0000_0002, 5'd1, OP_SRL, 4'h2, 32'h0000_0001, 1'b0);
        run_single(32'h0000_0003, 5'd1, OP_SRL, 4'h3, 32'h0000_0001, 1'b1);
        run_single(32'h8000_0001, 5'd1, OP_SRA, 4'h4, 32'hC000_0000, 1'b1);
        run_single(32'h8000_0001, 5'd1, OP_ROL, 4'h5, 32'h0000_0003, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
